// File: rtl/jtsdram_multichk.sv
// -----------------------------------------------------------------------------
// jtsdram_multichk
// SDRAM bank exerciser for the JTSDRAM test core. For every enabled bank it
// writes an address-derived pattern over a SPAN-word window starting at BASE,
// reads the window back and compares. Mismatches and timeouts are counted per
// bank, and the first failing location of a run is captured. Optional looping
// repeats the test, inverting the pattern on every pass.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             one-cycle pulse, begins a run from IDLE
//   stop              level, ends the run after the current access completes
//   loop              sampled at pass end, 1 = run another pass
//   ba_addr           per-bank word address, bank b at [b*AW +: AW]
//   ba_rd / ba_wr     per-bank read / write request
//   ba_din            write data shared by all banks
//   ba_din_m          byte write mask, never masks
//   ba_ack / ba_rdy   per-bank request accepted / access complete
//   data_read         read data, bits [DW-1:0] compared
//   refresh_en        high while no access is in flight
//   busy / done       run in progress / run ended (cleared by start)
//   pass_cnt          completed passes, wraps
//   err_cnt           per-bank error count (8 bits each), saturating
//   tout_flag         per-bank sticky timeout flag
//   first_err_bank    bank of the first error of the run
//   first_err_addr    address of the first error of the run
//   err_any           at least one error in the run
// -----------------------------------------------------------------------------
module jtsdram_multichk #(
  parameter int BANKS = 4,
  parameter int AW    = 22,
  parameter int DW    = 16,
  parameter int SPAN  = 1024,
  parameter int BASE  = 0,
  parameter int TOUT  = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop,
  output logic [BANKS*AW-1:0]   ba_addr,
  output logic [BANKS-1:0]      ba_rd,
  output logic [BANKS-1:0]      ba_wr,
  output logic [DW-1:0]         ba_din,
  output logic [DW/8-1:0]       ba_din_m,
  input  logic [BANKS-1:0]      ba_ack,
  input  logic [BANKS-1:0]      ba_rdy,
  input  logic [31:0]           data_read,
  output logic                  refresh_en,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           pass_cnt,
  output logic [BANKS*8-1:0]    err_cnt,
  output logic [BANKS-1:0]      tout_flag,
  output logic [1:0]            first_err_bank,
  output logic [AW-1:0]         first_err_addr,
  output logic                  err_any
);

  localparam int IW = (SPAN > 1) ? $clog2(SPAN) : 1;
  localparam int TW = $clog2(TOUT + 1) + 1;
  localparam int XW = (AW > DW) ? AW : DW;
  localparam logic [AW-1:0] BASE_A = AW'(BASE);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_WAIT = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_NEXT    = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  // Test pattern: address zero-extended to DW bits, inverted on odd passes.
  function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a, input logic inv);
    logic [XW-1:0] ax;
    ax = XW'(a);
    return ax[DW-1:0] ^ {DW{inv}};
  endfunction

  state_t                 state_q, state_d;
  logic [1:0]             bank_q, bank_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   p_q, p_d;
  logic [TW-1:0]          tmr_q, tmr_d;
  logic                   stop_pend_q, stop_pend_d;
  logic [BANKS*AW-1:0]    ba_addr_q, ba_addr_d;
  logic [BANKS-1:0]       ba_rd_q, ba_rd_d;
  logic [BANKS-1:0]       ba_wr_q, ba_wr_d;
  logic [DW-1:0]          ba_din_q, ba_din_d;
  logic                   refresh_en_q, refresh_en_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [15:0]            pass_cnt_q, pass_cnt_d;
  logic [BANKS*8-1:0]     err_cnt_q, err_cnt_d;
  logic [BANKS-1:0]       tout_flag_q, tout_flag_d;
  logic [1:0]             first_err_bank_q, first_err_bank_d;
  logic [AW-1:0]          first_err_addr_q, first_err_addr_d;
  logic                   err_any_q, err_any_d;

  logic [BANKS-1:0]       sel_s;
  logic                   rdy_s;
  logic                   ack_s;
  logic                   tmo_s;
  logic                   req_s;
  logic                   stop_s;
  logic                   fin_s;
  logic                   is_rd_s;
  logic                   bad_s;
  logic [AW-1:0]          addr_s;
  logic [DW-1:0]          pat_s;
  logic                   unused_data_s;

  // Only DW bits of the read bus take part in the compare.
  assign unused_data_s = ^data_read;

  // Next-state and next-output computation for the whole exerciser.
  always_comb begin
    state_d          = state_q;
    bank_d           = bank_q;
    idx_d            = idx_q;
    p_d              = p_q;
    tmr_d            = tmr_q;
    ba_addr_d        = ba_addr_q;
    ba_rd_d          = ba_rd_q;
    ba_wr_d          = ba_wr_q;
    ba_din_d         = ba_din_q;
    refresh_en_d     = refresh_en_q;
    busy_d           = busy_q;
    done_d           = done_q;
    pass_cnt_d       = pass_cnt_q;
    err_cnt_d        = err_cnt_q;
    tout_flag_d      = tout_flag_q;
    first_err_bank_d = first_err_bank_q;
    first_err_addr_d = first_err_addr_q;
    err_any_d        = err_any_q;
    // stop is remembered so a short pulse (or one coinciding with start)
    // still ends the run at the next access completion.
    stop_pend_d      = busy_q ? (stop_pend_q | stop) : 1'b0;
    fin_s            = 1'b0;
    bad_s            = 1'b0;

    for (int b = 0; b < BANKS; b++) begin
      sel_s[b] = (bank_q == 2'(b));
    end
    rdy_s   = |(ba_rdy & sel_s);
    ack_s   = |(ba_ack & sel_s);
    tmo_s   = (tmr_q == TW'(TOUT - 1));
    req_s   = |{ba_wr_q, ba_rd_q};
    stop_s  = stop | stop_pend_q;
    is_rd_s = (state_q == ST_RD_REQ) || (state_q == ST_RD_WAIT);
    addr_s  = BASE_A + AW'(idx_q);
    pat_s   = pattern(addr_s, p_q);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          busy_d           = 1'b1;
          done_d           = 1'b0;
          err_cnt_d        = '0;
          tout_flag_d      = '0;
          err_any_d        = 1'b0;
          first_err_bank_d = 2'd0;
          first_err_addr_d = '0;
          pass_cnt_d       = 16'd0;
          bank_d           = 2'd0;
          idx_d            = '0;
          p_d              = 1'b0;
          stop_pend_d      = stop;
          state_d          = ST_WR_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WR_REQ, ST_RD_REQ: begin
        if (!req_s) begin
          // First cycle in the state: raise the request for the next cycle.
          tmr_d        = '0;
          refresh_en_d = 1'b0;
          for (int b = 0; b < BANKS; b++) begin
            if (sel_s[b]) begin
              ba_addr_d[b*AW +: AW] = addr_s;
            end else begin
              ba_addr_d[b*AW +: AW] = ba_addr_q[b*AW +: AW];
            end
          end
          if (state_q == ST_WR_REQ) begin
            ba_wr_d  = sel_s;
            ba_din_d = pat_s;
          end else begin
            ba_rd_d  = sel_s;
          end
        end else if (rdy_s || tmo_s) begin
          // rdy before (or together with) ack is a completed access.
          fin_s = 1'b1;
        end else if (ack_s) begin
          ba_wr_d = '0;
          ba_rd_d = '0;
          tmr_d   = tmr_q + TW'(1);
          state_d = is_rd_s ? ST_RD_WAIT : ST_WR_WAIT;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end

      ST_WR_WAIT, ST_RD_WAIT: begin
        if (rdy_s || tmo_s) begin
          fin_s = 1'b1;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end

      ST_NEXT: begin
        if (bank_q == 2'(BANKS - 1)) begin
          pass_cnt_d = pass_cnt_q + 16'd1;
          p_d        = ~p_q;
          bank_d     = 2'd0;
          state_d    = (loop && !stop_s) ? ST_WR_REQ : ST_DONE;
        end else begin
          bank_d  = bank_q + 2'd1;
          state_d = ST_WR_REQ;
        end
      end

      ST_DONE: begin
        done_d      = 1'b1;
        busy_d      = 1'b0;
        stop_pend_d = 1'b0;
        state_d     = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Access completion: shared by both request and wait states.
    if (fin_s) begin
      ba_wr_d      = '0;
      ba_rd_d      = '0;
      refresh_en_d = 1'b1;
      // A timeout is an error; a completed write never is.
      bad_s        = rdy_s ? (is_rd_s && (data_read[DW-1:0] != pat_s)) : 1'b1;
      if (bad_s) begin
        for (int b = 0; b < BANKS; b++) begin
          if (sel_s[b] && (err_cnt_q[b*8 +: 8] != 8'hFF)) begin
            err_cnt_d[b*8 +: 8] = err_cnt_q[b*8 +: 8] + 8'd1;
          end else begin
            err_cnt_d[b*8 +: 8] = err_cnt_q[b*8 +: 8];
          end
        end
        if (!rdy_s) begin
          tout_flag_d = tout_flag_q | sel_s;
        end else begin
          tout_flag_d = tout_flag_q;
        end
        if (!err_any_q) begin
          err_any_d        = 1'b1;
          first_err_bank_d = bank_q;
          first_err_addr_d = addr_s;
        end else begin
          err_any_d        = err_any_q;
        end
      end else begin
        err_cnt_d = err_cnt_q;
      end

      if (stop_s) begin
        state_d = ST_DONE;
      end else if (idx_q == IW'(SPAN - 1)) begin
        idx_d   = '0;
        state_d = is_rd_s ? ST_NEXT : ST_RD_REQ;
      end else begin
        idx_d   = idx_q + IW'(1);
        state_d = is_rd_s ? ST_RD_REQ : ST_WR_REQ;
      end
    end else begin
      bad_s = 1'b0;
    end
  end

  // State and output registers; reset drops any request immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      bank_q           <= 2'd0;
      idx_q            <= '0;
      p_q              <= 1'b0;
      tmr_q            <= '0;
      stop_pend_q      <= 1'b0;
      ba_addr_q        <= '0;
      ba_rd_q          <= '0;
      ba_wr_q          <= '0;
      ba_din_q         <= '0;
      refresh_en_q     <= 1'b1;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_cnt_q       <= 16'd0;
      err_cnt_q        <= '0;
      tout_flag_q      <= '0;
      first_err_bank_q <= 2'd0;
      first_err_addr_q <= '0;
      err_any_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      bank_q           <= bank_d;
      idx_q            <= idx_d;
      p_q              <= p_d;
      tmr_q            <= tmr_d;
      stop_pend_q      <= stop_pend_d;
      ba_addr_q        <= ba_addr_d;
      ba_rd_q          <= ba_rd_d;
      ba_wr_q          <= ba_wr_d;
      ba_din_q         <= ba_din_d;
      refresh_en_q     <= refresh_en_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      pass_cnt_q       <= pass_cnt_d;
      err_cnt_q        <= err_cnt_d;
      tout_flag_q      <= tout_flag_d;
      first_err_bank_q <= first_err_bank_d;
      first_err_addr_q <= first_err_addr_d;
      err_any_q        <= err_any_d;
    end
  end

  assign ba_addr        = ba_addr_q;
  assign ba_rd          = ba_rd_q;
  assign ba_wr          = ba_wr_q;
  assign ba_din         = ba_din_q;
  assign ba_din_m       = '0;
  assign refresh_en     = refresh_en_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass_cnt       = pass_cnt_q;
  assign err_cnt        = err_cnt_q;
  assign tout_flag      = tout_flag_q;
  assign first_err_bank = first_err_bank_q;
  assign first_err_addr = first_err_addr_q;
  assign err_any        = err_any_q;

endmodule
